// File: rtl/new_task_arbiter_pkg.sv
// Shared OmpSs manager constants and types used by the new-task arbiter and
// its stream interface.
package new_task_arbiter_pkg;

    localparam int TDATA_W = 64;
    localparam int TDEST_W = 5;

    // Header word layout of a new-task packet
    localparam int NEW_TASK_DEPS_B = 4;
    localparam int TASK_SEQ_ID_H   = 63;
    localparam int TASK_SEQ_ID_L   = 32;

    localparam logic [TDEST_W-1:0] HWR_DEPS_ID  = 5'd1;
    localparam logic [TDEST_W-1:0] HWR_SCHED_ID = 5'd2;

    typedef enum logic {ARB, XFER} Arb_State_t;

    function automatic logic [TDEST_W-1:0] hdr_dest(input logic [TDATA_W-1:0] hdr);
        return hdr[NEW_TASK_DEPS_B] ? HWR_DEPS_ID : HWR_SCHED_ID;
    endfunction

endpackage

// File: rtl/new_task_arbiter_if.sv
// Per-accelerator request streams plus the merged output stream.
// master = stream environment, slave = arbiter.
interface new_task_arbiter_if
    import new_task_arbiter_pkg::*;
#(
    parameter int ACC_BITS = 4,
    parameter int NUM_ACCS = 16
);
    logic [NUM_ACCS-1:0]         in_tvalid;
    logic [NUM_ACCS-1:0]         in_tready;
    logic [NUM_ACCS*TDATA_W-1:0] in_tdata;
    logic [NUM_ACCS-1:0]         in_tlast;

    logic                        outStream_tvalid;
    logic                        outStream_tready;
    logic [TDATA_W-1:0]          outStream_tdata;
    logic                        outStream_tlast;
    logic [ACC_BITS-1:0]         outStream_tid;
    logic [TDEST_W-1:0]          outStream_tdest;

    modport master (
        output in_tvalid, in_tdata, in_tlast, outStream_tready,
        input  in_tready, outStream_tvalid, outStream_tdata, outStream_tlast,
               outStream_tid, outStream_tdest
    );

    modport slave (
        input  in_tvalid, in_tdata, in_tlast, outStream_tready,
        output in_tready, outStream_tvalid, outStream_tdata, outStream_tlast,
               outStream_tid, outStream_tdest
    );

endinterface

// File: rtl/new_task_arbiter_rr_priority_picker.sv
// Round-robin picker: first requester after last_grant_i, wrapping at
// NUM_ACCS rather than at the index width.
module rr_priority_picker #(
    parameter int NUM_ACCS = 16,
    parameter int IDX_BITS = 4
) (
    input  logic [NUM_ACCS-1:0] req_i,
    input  logic [IDX_BITS-1:0] last_grant_i,
    output logic                found_o,
    output logic [IDX_BITS-1:0] idx_o
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_ACCS - 1);

    logic [IDX_BITS-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = last_grant_i;
        for (int k = 0; k < NUM_ACCS; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + IDX_BITS'(1);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/new_task_arbiter.sv
// Packet-granular round-robin merge of accelerator new-task streams into the
// cutoff-manager stream, tagging tid and routing tdest from the header.
module new_task_arbiter
    import new_task_arbiter_pkg::*;
#(
    parameter int ACC_BITS = 4,
    parameter int NUM_ACCS = 16
) (
    input logic               clk,
    input logic               rst,
    new_task_arbiter_if.slave bus
);

    Arb_State_t          state_q, state_d;
    logic [ACC_BITS-1:0] grant_q, grant_d;
    logic [ACC_BITS-1:0] last_grant_q, last_grant_d;
    logic                first_beat_q, first_beat_d;
    logic [TDEST_W-1:0]  cur_dest_q, cur_dest_d;

    logic                ovalid_q, ovalid_d;
    logic [TDATA_W-1:0]  odata_q, odata_d;
    logic                olast_q, olast_d;
    logic [ACC_BITS-1:0] otid_q, otid_d;
    logic [TDEST_W-1:0]  odest_q, odest_d;

    logic                found;
    logic [ACC_BITS-1:0] pick_idx;
    logic                out_free;
    logic                accept;
    logic [TDATA_W-1:0]  beat_data;
    logic                beat_last;

    rr_priority_picker #(
        .NUM_ACCS (NUM_ACCS),
        .IDX_BITS (ACC_BITS)
    ) u_picker (
        .req_i        (bus.in_tvalid),
        .last_grant_i (last_grant_q),
        .found_o      (found),
        .idx_o        (pick_idx)
    );

    assign beat_data = bus.in_tdata[{grant_q, 6'b0} +: TDATA_W];
    assign beat_last = bus.in_tlast[grant_q];
    // obuf can take a beat when empty or draining this cycle
    assign out_free  = !ovalid_q || bus.outStream_tready;
    assign accept    = (state_q == XFER) && out_free && bus.in_tvalid[grant_q];

    always_comb begin
        bus.in_tready = '0;
        if (state_q == XFER) bus.in_tready[grant_q] = out_free;
    end

    assign bus.outStream_tvalid = ovalid_q;
    assign bus.outStream_tdata  = odata_q;
    assign bus.outStream_tlast  = olast_q;
    assign bus.outStream_tid    = otid_q;
    assign bus.outStream_tdest  = odest_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_beat_d = first_beat_q;
        cur_dest_d   = cur_dest_q;
        ovalid_d     = ovalid_q && !bus.outStream_tready;
        odata_d      = odata_q;
        olast_d      = olast_q;
        otid_d       = otid_q;
        odest_d      = odest_q;

        case (state_q)
            ARB: begin
                if (found) begin
                    grant_d      = pick_idx;
                    last_grant_d = pick_idx;
                    first_beat_d = 1'b1;
                    state_d      = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    ovalid_d     = 1'b1;
                    odata_d      = beat_data;
                    olast_d      = beat_last;
                    otid_d       = grant_q;
                    odest_d      = first_beat_q ? hdr_dest(beat_data) : cur_dest_q;
                    if (first_beat_q) cur_dest_d = hdr_dest(beat_data);
                    first_beat_d = 1'b0;
                    if (beat_last) state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            grant_q      <= '0;
            last_grant_q <= ACC_BITS'(NUM_ACCS - 1);
            first_beat_q <= 1'b1;
            cur_dest_q   <= HWR_SCHED_ID;
            ovalid_q     <= 1'b0;
            odata_q      <= '0;
            olast_q      <= 1'b0;
            otid_q       <= '0;
            odest_q      <= HWR_SCHED_ID;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_beat_q <= first_beat_d;
            cur_dest_q   <= cur_dest_d;
            ovalid_q     <= ovalid_d;
            odata_q      <= odata_d;
            olast_q      <= olast_d;
            otid_q       <= otid_d;
            odest_q      <= odest_d;
        end
    end

endmodule

// File: tb/tb_new_task_arbiter.sv
// Bench for new_task_arbiter: per-source packet queues feed the DUT, the
// merged output is compared with per-source expected FIFOs and grant order.
module tb_new_task_arbiter;
    import new_task_arbiter_pkg::*;

    localparam int AB = 4;
    localparam int NA = 16;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          tid;
        logic [4:0]  dest;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    new_task_arbiter_if #(.ACC_BITS(AB), .NUM_ACCS(NA)) bus ();

    new_task_arbiter #(.ACC_BITS(AB), .NUM_ACCS(NA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    beat_t          src_q   [NA][$];
    beat_t          exp_src [NA][$];
    beat_t          got     [$];
    logic [NA-1:0]  stall   = '0;
    int             vld_pct = 100;
    int             rdy_pct = 100;
    bit             rdy_low = 1'b0;
    int             cyc     = 0;
    int             checks  = 0;
    int             errors  = 0;

    // Source/sink driver: record handshakes at negedge, drive after posedge
    initial begin
        beat_t b;
        bus.in_tvalid        = '0;
        bus.in_tdata         = '0;
        bus.in_tlast         = '0;
        bus.outStream_tready = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NA; i++)
                if (bus.in_tvalid[i] && bus.in_tready[i] && src_q[i].size() > 0)
                    void'(src_q[i].pop_front());
            if (bus.outStream_tvalid && bus.outStream_tready) begin
                b.data = bus.outStream_tdata;
                b.last = bus.outStream_tlast;
                b.tid  = int'(bus.outStream_tid);
                b.dest = bus.outStream_tdest;
                got.push_back(b);
            end
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < NA; i++) begin
                if (src_q[i].size() > 0 && !stall[i] && $urandom_range(99) < vld_pct) begin
                    bus.in_tvalid[i]         = 1'b1;
                    bus.in_tdata[64*i +: 64] = src_q[i][0].data;
                    bus.in_tlast[i]          = src_q[i][0].last;
                end else begin
                    bus.in_tvalid[i] = 1'b0;
                end
            end
            bus.outStream_tready = !rdy_low && ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic send_pkt(input int src, input int n, input bit deps,
                            input logic [63:0] d0, input bit rnd);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = rnd ? {$urandom, $urandom} : d0 + 64'(k) * 64'h11;
            if (k == 0) b.data[NEW_TASK_DEPS_B] = deps;
            b.last = (k == n - 1);
            b.tid  = src;
            b.dest = deps ? HWR_DEPS_ID : HWR_SCHED_ID;
            src_q[src].push_back(b);
            exp_src[src].push_back(b);
        end
    endtask

    task automatic wait_got(input int n, input int budget, output bit ok);
        int k = 0;
        while (got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (got.size() >= n);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.outStream_tvalid !== 1'b0 || bus.in_tready !== '0) begin
            errors++;
            $display("FAIL reset_state: tvalid=%b in_tready=%h, want 0 and 0",
                     bus.outStream_tvalid, bus.in_tready);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.outStream_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: tvalid=%b want 0", bus.outStream_tvalid);
        end
    endtask

    task automatic test_single_source();
        int t0 = -1, t1 = -1, k = 0;
        bit ok;
        beat_t e;
        got.delete();
        send_pkt(3, 3, 1'b1, 64'h11, 1'b0);
        while ((t0 < 0 || t1 < 0) && k < 50) begin
            @(negedge clk);
            k++;
            if (t0 < 0 && bus.in_tvalid[3]) t0 = cyc;
            if (t1 < 0 && bus.outStream_tvalid) t1 = cyc;
        end
        checks++;
        if (t0 < 0 || t1 < 0 || t1 - t0 != 2) begin
            errors++;
            $display("FAIL first_beat_latency: got %0d cycles want 2", t1 - t0);
        end
        wait_got(3, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_src_timeout: got %0d beats want 3", got.size());
        end
        for (int j = 0; j < 3 && j < got.size(); j++) begin
            e = exp_src[3].pop_front();
            checks++;
            if (got[j].data !== e.data || got[j].tid !== 3 || got[j].dest !== HWR_DEPS_ID ||
                got[j].last !== (j == 2)) begin
                errors++;
                $display("FAIL single_src beat%0d: got d=%h tid=%0d dest=%0d last=%b want d=%h tid=3 dest=%0d last=%b",
                         j, got[j].data, got[j].tid, got[j].dest, got[j].last,
                         e.data, HWR_DEPS_ID, (j == 2));
            end
        end
    endtask

    task automatic test_rotation3();
        int want[$] = '{0, 0, 1, 1, 2, 2};
        bit ok;
        beat_t e;
        got.delete();
        for (int s = 0; s < 3; s++) send_pkt(s, 2, s[0], 64'h100 * (s + 1), 1'b1);
        wait_got(want.size(), 100, ok);
        for (int j = 0; j < want.size(); j++) begin
            checks++;
            if (j >= got.size() || exp_src[want[j]].size() == 0) begin
                errors++;
                $display("FAIL rotation3 beat%0d: missing, want tid=%0d", j, want[j]);
            end else begin
                e = exp_src[want[j]].pop_front();
                if (got[j].tid !== e.tid || got[j].data !== e.data ||
                    got[j].last !== e.last || got[j].dest !== e.dest) begin
                    errors++;
                    $display("FAIL rotation3 beat%0d: got tid=%0d d=%h last=%b dest=%0d want tid=%0d d=%h last=%b dest=%0d",
                             j, got[j].tid, got[j].data, got[j].last, got[j].dest,
                             e.tid, e.data, e.last, e.dest);
                end
            end
        end
    endtask

    task automatic test_hold_grant();
        int want[$] = '{5, 5, 5, 6, 6};
        int k = 0;
        bit ok;
        beat_t e;
        got.delete();
        send_pkt(5, 3, 1'b0, 0, 1'b1);
        send_pkt(6, 2, 1'b1, 0, 1'b1);
        while (!(bus.in_tvalid[5] && bus.in_tready[5]) && k < 50) begin
            @(negedge clk);
            k++;
        end
        stall[5] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.in_tready[6] !== 1'b0) begin
                errors++;
                $display("FAIL hold_grant: in_tready[6]=%b want 0 while source 5 mid-packet",
                         bus.in_tready[6]);
            end
        end
        stall[5] = 1'b0;
        wait_got(want.size(), 100, ok);
        for (int j = 0; j < want.size(); j++) begin
            checks++;
            if (j >= got.size() || exp_src[want[j]].size() == 0) begin
                errors++;
                $display("FAIL hold_order beat%0d: missing, want tid=%0d", j, want[j]);
            end else begin
                e = exp_src[want[j]].pop_front();
                if (got[j].tid !== e.tid || got[j].data !== e.data ||
                    got[j].last !== e.last || got[j].dest !== e.dest) begin
                    errors++;
                    $display("FAIL hold_order beat%0d: got tid=%0d d=%h dest=%0d want tid=%0d d=%h dest=%0d",
                             j, got[j].tid, got[j].data, got[j].dest, e.tid, e.data, e.dest);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        bit ok;
        logic [63:0] held;
        beat_t e;
        got.delete();
        rdy_low = 1'b1;
        send_pkt(1, 4, 1'b1, 64'hA0, 1'b0);
        while (!bus.outStream_tvalid && k < 50) begin
            @(negedge clk);
            k++;
        end
        held = bus.outStream_tdata;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (bus.in_tready[1] !== 1'b0 || bus.outStream_tvalid !== 1'b1 ||
                bus.outStream_tdata !== held) begin
                errors++;
                $display("FAIL backpressure: in_tready=%b tvalid=%b d=%h want 0 1 %h",
                         bus.in_tready[1], bus.outStream_tvalid, bus.outStream_tdata, held);
            end
        end
        rdy_low = 1'b0;
        wait_got(4, 100, ok);
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (j >= got.size() || exp_src[1].size() == 0) begin
                errors++;
                $display("FAIL backpressure_order beat%0d: missing", j);
            end else begin
                e = exp_src[1].pop_front();
                if (got[j].tid !== 1 || got[j].data !== e.data || got[j].last !== e.last ||
                    got[j].dest !== e.dest) begin
                    errors++;
                    $display("FAIL backpressure_order beat%0d: got tid=%0d d=%h want tid=1 d=%h",
                             j, got[j].tid, got[j].data, e.data);
                end
            end
        end
    endtask

    task automatic test_single_beat_wrap();
        int want[$] = '{15, 0, 14};
        bit ok;
        beat_t e;
        got.delete();
        send_pkt(15, 1, 1'b0, 0, 1'b1);
        wait_got(1, 50, ok);
        send_pkt(14, 1, 1'b1, 0, 1'b1);
        send_pkt(0, 1, 1'b0, 0, 1'b1);
        wait_got(3, 50, ok);
        for (int j = 0; j < want.size(); j++) begin
            checks++;
            if (j >= got.size() || exp_src[want[j]].size() == 0) begin
                errors++;
                $display("FAIL single_wrap beat%0d: missing, want tid=%0d", j, want[j]);
            end else begin
                e = exp_src[want[j]].pop_front();
                if (got[j].tid !== e.tid || got[j].dest !== e.dest ||
                    got[j].last !== 1'b1 || got[j].data !== e.data) begin
                    errors++;
                    $display("FAIL single_wrap beat%0d: got tid=%0d dest=%0d last=%b want tid=%0d dest=%0d last=1",
                             j, got[j].tid, got[j].dest, got[j].last, e.tid, e.dest);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        int want[$] = '{0, 4};
        int k = 0;
        bit ok;
        beat_t e;
        got.delete();
        rdy_low = 1'b1;
        send_pkt(2, 4, 1'b1, 0, 1'b1);
        while (!bus.outStream_tvalid && k < 50) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        src_q[2].delete();
        exp_src[2].delete();
        @(negedge clk);
        checks++;
        if (bus.outStream_tvalid !== 1'b0 || bus.in_tready !== '0) begin
            errors++;
            $display("FAIL rst_mid: tvalid=%b in_tready=%h want 0 and 0",
                     bus.outStream_tvalid, bus.in_tready);
        end
        rst = 1'b0;
        rdy_low = 1'b0;
        got.delete();
        send_pkt(4, 1, 1'b0, 0, 1'b1);
        send_pkt(0, 1, 1'b1, 0, 1'b1);
        wait_got(2, 50, ok);
        for (int j = 0; j < want.size(); j++) begin
            checks++;
            if (j >= got.size() || exp_src[want[j]].size() == 0) begin
                errors++;
                $display("FAIL rst_recover beat%0d: missing, want tid=%0d", j, want[j]);
            end else begin
                e = exp_src[want[j]].pop_front();
                if (got[j].tid !== e.tid || got[j].data !== e.data || got[j].dest !== e.dest) begin
                    errors++;
                    $display("FAIL rst_recover beat%0d: got tid=%0d d=%h want tid=%0d d=%h",
                             j, got[j].tid, got[j].data, e.tid, e.data);
                end
            end
        end
    endtask

    task automatic test_all_rotation();
        int want[$];
        bit ok;
        beat_t e;
        got.delete();
        // Source 4 was granted last, so rotation starts at 5
        for (int k = 0; k < NA; k++) begin
            want.push_back((5 + k) % NA);
            want.push_back((5 + k) % NA);
        end
        want.push_back(4);
        for (int s = 0; s < NA; s++) send_pkt(s, 2, s[1], 0, 1'b1);
        wait_got(2 * NA, 400, ok);
        send_pkt(4, 1, 1'b1, 0, 1'b1);
        wait_got(2 * NA + 1, 50, ok);
        for (int j = 0; j < want.size(); j++) begin
            checks++;
            if (j >= got.size() || exp_src[want[j]].size() == 0) begin
                errors++;
                $display("FAIL all_rotation beat%0d: missing, want tid=%0d", j, want[j]);
            end else begin
                e = exp_src[want[j]].pop_front();
                if (got[j].tid !== e.tid || got[j].data !== e.data ||
                    got[j].last !== e.last || got[j].dest !== e.dest) begin
                    errors++;
                    $display("FAIL all_rotation beat%0d: got tid=%0d d=%h want tid=%0d d=%h",
                             j, got[j].tid, got[j].data, e.tid, e.data);
                end
            end
        end
    endtask

    task automatic test_random();
        int  sent = 0, total = 0, done = 0, k = 0, cur = -1;
        bit  in_pkt = 1'b0;
        int  n;
        beat_t g, e;
        got.delete();
        vld_pct = 70;
        rdy_pct = 60;
        while ((sent < 40 || done < total) && k < 8000) begin
            @(negedge clk);
            k++;
            if (sent < 40 && $urandom_range(3) == 0) begin
                n = int'($urandom_range(4, 1));
                send_pkt(int'($urandom_range(NA - 1)), n, 1'($urandom_range(1)), 0, 1'b1);
                total += n;
                sent++;
            end
            while (got.size() > 0) begin
                g = got.pop_front();
                done++;
                checks++;
                if (in_pkt && g.tid != cur) begin
                    errors++;
                    $display("FAIL random_interleave: got tid=%0d want tid=%0d", g.tid, cur);
                end else if (g.tid < 0 || g.tid >= NA || exp_src[g.tid].size() == 0) begin
                    errors++;
                    $display("FAIL random_unexpected: got tid=%0d d=%h with no pending beat", g.tid, g.data);
                end else begin
                    e = exp_src[g.tid].pop_front();
                    if (g.data !== e.data || g.last !== e.last || g.dest !== e.dest) begin
                        errors++;
                        $display("FAIL random_beat tid=%0d: got d=%h last=%b dest=%0d want d=%h last=%b dest=%0d",
                                 g.tid, g.data, g.last, g.dest, e.data, e.last, e.dest);
                    end
                end
                cur    = g.tid;
                in_pkt = !g.last;
            end
        end
        checks++;
        if (done != total || sent != 40) begin
            errors++;
            $display("FAIL random_drain: got %0d beats want %0d", done, total);
        end
        vld_pct = 100;
        rdy_pct = 100;
    endtask

    initial begin
        test_reset();
        test_single_source();
        test_rotation3();
        test_hold_grant();
        test_backpressure();
        test_single_beat_wrap();
        test_rst_mid();
        test_all_rotation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
